// File: rtl/opacc_ctrl.sv
// Command sequencer for the outer-product accumulator: turns LOAD/MAC/STORE/XCHG
// commands into accumulator strobes and stream handshakes. Optional perf counters: OPACC_CTRL_PERF_EN.
module opacc_ctrl #(
  parameter int NREGS = 2,
  parameter int ML    = 4,
  parameter int KMAX  = 16,
  localparam int RW   = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int LW   = $clog2(KMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_reg,
  input  logic [LW-1:0] cmd_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          abq_valid,
  output logic          abq_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          ab_valid,
  output logic          ci_valid,
  output logic          ci_zero,
  output logic [RW-1:0] ab_addr,
  output logic [RW-1:0] ci_addr,
  output logic [RW-1:0] co_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   perf_busy,
  output logic [31:0]   perf_stall
);
  localparam int CMAX = (ML > KMAX) ? ML : KMAX;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [31:0] NREGS_W = NREGS;
  localparam logic [31:0] KMAX_W  = KMAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_STORE, S_XCHG} state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [RW-1:0] rg;
    logic [LW-1:0] len;
  } cmd_t;

  state_t        state;
  logic [RW-1:0] cur_reg;
  logic [CW-1:0] cnt;
  logic          fire;
  logic          illegal;
  cmd_t          cmd;

  assign cmd     = '{op: cmd_op, rg: cmd_reg, len: cmd_len};
  assign illegal = ({{(32-RW){1'b0}}, cmd.rg} >= NREGS_W) ||
                   ((cmd.op == 2'd1) && ({{(32-LW){1'b0}}, cmd.len} > KMAX_W));

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ab_addr   = cur_reg;
  assign ci_addr   = cur_reg;
  assign co_addr   = cur_reg;

  // Beat outputs are purely combinational so the accumulator sees the fire in the handshake cycle.
  always_comb begin
    fire      = 1'b0;
    in_ready  = 1'b0;
    abq_ready = 1'b0;
    out_valid = 1'b0;
    ab_valid  = 1'b0;
    ci_valid  = 1'b0;
    ci_zero   = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        fire     = in_valid;
        ci_valid = in_valid;
      end
      S_MAC: begin
        abq_ready = 1'b1;
        fire      = abq_valid;
        ab_valid  = abq_valid;
      end
      S_STORE: begin
        out_valid = 1'b1;
        fire      = out_ready;
        ci_valid  = out_ready;
        ci_zero   = 1'b1;
      end
      S_XCHG: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        fire      = in_valid & out_ready;
        ci_valid  = in_valid & out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cur_reg <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE) begin
        if (cmd_valid) begin
          if (illegal) begin
            err <= 1'b1;
          end else begin
            cur_reg <= cmd.rg;
            case (cmd.op)
              2'd0: begin state <= S_LOAD;  cnt <= CW'(ML); end
              2'd2: begin state <= S_STORE; cnt <= CW'(ML); end
              2'd3: begin state <= S_XCHG;  cnt <= CW'(ML); end
              default: begin
                // A zero-step MAC has nothing to issue, so it completes straight from IDLE.
                if (cmd.len == '0) done <= 1'b1;
                else begin
                  state <= S_MAC;
                  cnt   <= CW'(cmd.len);
                end
              end
            endcase
          end
        end
      end else if (fire) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef OPACC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (busy) begin
      if (perf_busy != '1) perf_busy <= perf_busy + 32'd1;
      if (!fire && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_opacc_ctrl.sv
// Directed and random checks of opacc_ctrl against a beats-remaining command model.
module tb_opacc_ctrl;
  localparam int NREGS = 2, ML = 4, KMAX = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, in_valid = 1'b0, abq_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [0:0] cmd_reg = '0;
  logic [4:0] cmd_len = '0;
  logic cmd_ready, in_ready, abq_ready, out_valid, ab_valid, ci_valid, ci_zero;
  logic [0:0] ab_addr, ci_addr, co_addr;
  logic busy, done, err;
  logic [31:0] perf_busy, perf_stall;

  opacc_ctrl #(.NREGS(NREGS), .ML(ML), .KMAX(KMAX)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .abq_valid(abq_valid), .abq_ready(abq_ready),
    .out_ready(out_ready), .out_valid(out_valid), .ab_valid(ab_valid), .ci_valid(ci_valid),
    .ci_zero(ci_zero), .ab_addr(ab_addr), .ci_addr(ci_addr), .co_addr(co_addr),
    .busy(busy), .done(done), .err(err), .perf_busy(perf_busy), .perf_stall(perf_stall));

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  // Model: active op (-1 idle), beats still owed, target tile, pending pulses, perf tallies.
  int m_op = -1, m_left = 0, m_reg = 0;
  bit m_done = 0, m_err = 0;
  longint m_pb = 0, m_ps = 0;
  int ab_seen = 0, ci_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit cv, input int op, input int rg, input int ln,
                     input bit iv, input bit av, input bit ordy);
    bit e_fire, e_inr, e_abr, e_ov, e_abv, e_civ, e_ciz;
    reset = rs; cmd_valid = cv; cmd_op = 2'(op); cmd_reg = 1'(rg); cmd_len = 5'(ln);
    in_valid = iv; abq_valid = av; out_ready = ordy;
    #1;
    e_inr = (m_op == 0) || (m_op == 3 && ordy);
    e_abr = (m_op == 1);
    e_ov  = (m_op == 2) || (m_op == 3 && iv);
    e_abv = (m_op == 1 && av);
    e_civ = (m_op == 0 && iv) || (m_op == 2 && ordy) || (m_op == 3 && iv && ordy);
    e_ciz = (m_op == 2);
    e_fire = e_abv || e_civ;
    chk("cmd_ready", cmd_ready, m_op < 0);
    chk("busy", busy, m_op >= 0);
    chk("in_ready", in_ready, e_inr);
    chk("abq_ready", abq_ready, e_abr);
    chk("out_valid", out_valid, e_ov);
    chk("ab_valid", ab_valid, e_abv);
    chk("ci_valid", ci_valid, e_civ);
    chk("ci_zero", ci_zero, e_ciz);
    chk("addr", {ab_addr, ci_addr, co_addr}, {3{m_reg[0]}});
    chk("done", done, m_done);
    chk("err", err, m_err);
`ifdef OPACC_CTRL_PERF_EN
    chk("perf_busy", perf_busy, 32'(m_pb));
    chk("perf_stall", perf_stall, 32'(m_ps));
`else
    chk("perf_busy", perf_busy, 0);
    chk("perf_stall", perf_stall, 0);
`endif
    if (ab_valid) ab_seen++;
    if (ci_valid) ci_seen++;
    @(posedge clk);
    if (rs) begin
      m_op = -1; m_left = 0; m_reg = 0; m_done = 0; m_err = 0; m_pb = 0; m_ps = 0;
    end else if (m_op < 0) begin
      m_done = 0; m_err = 0;
      if (cv) begin
        if (rg >= NREGS || (op == 1 && ln > KMAX)) m_err = 1;
        else begin
          m_reg = rg;
          if (op == 1 && ln == 0) m_done = 1;
          else begin m_op = op; m_left = (op == 1) ? ln : ML; end
        end
      end
    end else begin
      m_done = 0; m_err = 0;
      m_pb = (m_pb < 64'hFFFF_FFFF) ? m_pb + 1 : m_pb;
      if (!e_fire) m_ps = (m_ps < 64'hFFFF_FFFF) ? m_ps + 1 : m_ps;
      else begin
        m_left--;
        if (m_left == 0) begin m_op = -1; m_done = 1; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk); @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);           // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // LOAD tile 1 with input always valid
    ci_seen = 0;
    cyc(0, 1, 0, 1, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("load_beats", ci_seen, 4);
    // MAC tile 0, three steps with operand gaps
    ab_seen = 0;
    cyc(0, 1, 1, 0, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mac_pulses", ab_seen, 3);
    // STORE with a two-cycle drain stall; busy command attempts ignored
    ci_seen = 0;
    cyc(0, 1, 2, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("store_beats", ci_seen, 4);
    // XCHG with out_ready alternating
    ci_seen = 0;
    cyc(0, 1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, 0, i[0]);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    chk("xchg_beats", ci_seen, 4);
    // Illegal MAC length and zero-length MAC
    cyc(0, 1, 1, 1, 17, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // Reset during the second LOAD beat, then a fresh command
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 20), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
